espiro_meas_sequencer: RTL and testbench

//  Timebase controller for one spirometer measurement. Owns its own seconds prescaler and sample-rate prescaler.

---
 rtl/espiro_meas_sequencer.sv | 155 +++++++++++++++
 tb/tb_espiro_meas_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/espiro_meas_sequencer.sv
// ---------------------------------------------------------------------------
// espiro_meas_sequencer : spirometer pre-blow countdown and timed measurement window
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module espiro_meas_sequencer #(
   parameter int TICK_DIV   = 50000000,
   parameter int SAMPLE_DIV = 500000,
   parameter int PRE_SECS   = 3,
   parameter int MEAS_SECS  = 6
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iStart,
   input  logic       iAbort,
   output logic [1:0] oPhase,
   output logic       oBusy,
   output logic [3:0] oCountdown,
   output logic       oSecTick,
   output logic       oSample,
   output logic       oDone,
   output logic       oAborted
);

   localparam int SEC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICK_DIV - 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_DIV - 1);
   localparam logic [3:0] PRE_CD  = 4'(PRE_SECS);
   localparam logic [3:0] MEAS_CD = 4'(MEAS_SECS);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PRE  = 2'b01,
      MEAS = 2'b10,
      DONE = 2'b11
   } phase_t;

   phase_t           phase_q, phase_d;
   logic [3:0]       cd_q, cd_d;
   logic [SEC_W-1:0] sec_q, sec_d, sec_next;
   logic [SMP_W-1:0] smp_q, smp_d, smp_next;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;
   logic             sample_q, sample_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         phase_q   <= IDLE;
         cd_q      <= '0;
         sec_q     <= '0;
         smp_q     <= '0;
         busy_q    <= 1'b0;
         tick_q    <= 1'b0;
         sample_q  <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         cd_q      <= cd_d;
         sec_q     <= sec_d;
         smp_q     <= smp_d;
         busy_q    <= busy_d;
         tick_q    <= tick_d;
         sample_q  <= sample_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   // tick_q/sample_q mirror the current prescaler values, so phase decisions act on the visible pulse
   always_comb begin
      phase_d   = phase_q;
      cd_d      = cd_q;
      sec_d     = '0;
      smp_d     = '0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      sec_next  = (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
      smp_next  = (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;

      case (phase_q)
         IDLE: begin
            if (iStart && !iAbort) begin
               phase_d = PRE;
               cd_d    = PRE_CD;
            end
         end
         PRE: begin
            if (iAbort) begin
               phase_d   = IDLE;
               cd_d      = '0;
               aborted_d = 1'b1;
            end else begin
               sec_d = sec_next;
               if (tick_q) begin
                  if (cd_q > 4'd1) begin
                     cd_d = cd_q - 4'd1;
                  end else begin
                     phase_d = MEAS;
                     cd_d    = MEAS_CD;
                  end
               end
            end
         end
         MEAS: begin
            if (iAbort) begin
               phase_d   = IDLE;
               cd_d      = '0;
               aborted_d = 1'b1;
            end else begin
               sec_d = sec_next;
               smp_d = smp_next;
               if (tick_q) begin
                  if (cd_q > 4'd1) begin
                     cd_d = cd_q - 4'd1;
                  end else begin
                     phase_d = DONE;
                     cd_d    = '0;
                     done_d  = 1'b1;
                     sec_d   = '0;
                     smp_d   = '0;
                  end
               end
            end
         end
         DONE: begin
            phase_d = IDLE;
            cd_d    = '0;
         end
         default: begin
            phase_d = IDLE;
            cd_d    = '0;
         end
      endcase

      busy_d   = (phase_d == PRE) || (phase_d == MEAS);
      tick_d   = busy_d && (sec_d == SEC_LAST);
      sample_d = (phase_d == MEAS) && (smp_d == SMP_LAST);
   end

   assign oPhase     = phase_q;
   assign oBusy      = busy_q;
   assign oCountdown = cd_q;
   assign oSecTick   = tick_q;
   assign oSample    = sample_q;
   assign oDone      = done_q;
   assign oAborted   = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_espiro_meas_sequencer.sv
// ---------------------------------------------------------------------------
// tb_espiro_meas_sequencer : vector table, corner sequences and randomized run vs timeline model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_espiro_meas_sequencer;

   localparam int TICK_DIV   = 10;
   localparam int SAMPLE_DIV = 4;
   localparam int PRE_SECS   = 2;
   localparam int MEAS_SECS  = 3;
   localparam int PT     = PRE_SECS * TICK_DIV;
   localparam int MT     = MEAS_SECS * TICK_DIV;
   localparam int DONE_E = PT + MT + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [1:0] phase;
   logic       busy;
   logic [3:0] cd;
   logic       tick;
   logic       sample;
   logic       done;
   logic       aborted;

   espiro_meas_sequencer #(
      .TICK_DIV   (TICK_DIV),
      .SAMPLE_DIV (SAMPLE_DIV),
      .PRE_SECS   (PRE_SECS),
      .MEAS_SECS  (MEAS_SECS)
   ) dut (
      .iClk       (clk),
      .iReset     (rst),
      .iStart     (start),
      .iAbort     (abort),
      .oPhase     (phase),
      .oBusy      (busy),
      .oCountdown (cd),
      .oSecTick   (tick),
      .oSample    (sample),
      .oDone      (done),
      .oAborted   (aborted)
   );

   always #5 clk = ~clk;

   logic [10:0] dut_v;
   assign dut_v = {phase, busy, cd, tick, sample, done, aborted};

   int total = 0;
   int bad   = 0;

   // Timeline model: a run is just its start cycle; everything follows from elapsed time
   int t_cyc = 0;
   bit m_run = 1'b0;
   int m_s   = 0;
   bit m_ab  = 1'b0;

   function automatic logic [10:0] ex(input logic [1:0] ph, input int c, input bit tk,
                                      input bit sp, input bit dn, input bit ab);
      return {ph, (ph == 2'd1) || (ph == 2'd2), 4'(c), tk, sp, dn, ab};
   endfunction

   function automatic logic [10:0] model_out();
      int e;
      logic [1:0] ph;
      int c;
      bit tk, sp, dn;
      ph = 2'd0; c = 0; tk = 1'b0; sp = 1'b0; dn = 1'b0;
      if (m_run) begin
         e = t_cyc - m_s;
         if (e <= PT) begin
            ph = 2'd1;
            c  = PRE_SECS - (e - 1) / TICK_DIV;
            tk = (e % TICK_DIV) == 0;
         end else if (e <= PT + MT) begin
            ph = 2'd2;
            c  = MEAS_SECS - (e - PT - 1) / TICK_DIV;
            tk = (e % TICK_DIV) == 0;
            sp = ((e - PT) % SAMPLE_DIV) == 0;
         end else begin
            ph = 2'd3;
            dn = 1'b1;
         end
      end
      return ex(ph, c, tk, sp, dn, m_ab);
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got={ph,busy,cd,tick,smp,done,abt}=%b req=%b",
                  name, t_cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      t_cyc = 0;
      m_run = 1'b0;
      m_ab  = 1'b0;
   endtask

   // One clock: drive inputs, advance DUT and model, compare against model
   task automatic step(input bit st, input bit ab);
      bit busy_now, free_now;
      start = st;
      abort = ab;
      @(posedge clk);
      #1;
      busy_now = m_run && ((t_cyc - m_s) <= PT + MT);
      free_now = !m_run;
      t_cyc++;
      m_ab = 1'b0;
      if (busy_now && ab) begin
         m_run = 1'b0;
         m_ab  = 1'b1;
      end else if (free_now && st && !ab) begin
         m_run = 1'b1;
         m_s   = t_cyc - 1;
      end
      if (m_run && (t_cyc - m_s) > DONE_E) m_run = 1'b0;
      check("model", dut_v, model_out());
      start = 1'b0;
      abort = 1'b0;
   endtask

   typedef struct {
      bit          st;
      bit          ab;
      int          hold;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      #1;
      check("reset_state", dut_v, 11'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (2) step(1'b0, 1'b0);

      // Full run from start at c0, with ignored starts, back-to-back and aborts
      tbl.push_back('{1, 0, 0,  ex(1, 2, 0, 0, 0, 0)});  // c1 PRE
      tbl.push_back('{0, 0, 8,  ex(1, 2, 1, 0, 0, 0)});  // c10 tick
      tbl.push_back('{1, 0, 0,  ex(1, 1, 0, 0, 0, 0)});  // c11 start ignored
      tbl.push_back('{0, 0, 8,  ex(1, 1, 1, 0, 0, 0)});  // c20 tick
      tbl.push_back('{0, 0, 0,  ex(2, 3, 0, 0, 0, 0)});  // c21 MEAS
      tbl.push_back('{0, 0, 2,  ex(2, 3, 0, 1, 0, 0)});  // c24 first sample
      tbl.push_back('{1, 0, 5,  ex(2, 3, 1, 0, 0, 0)});  // c30 tick
      tbl.push_back('{0, 0, 0,  ex(2, 2, 0, 0, 0, 0)});  // c31
      tbl.push_back('{0, 0, 18, ex(2, 1, 1, 0, 0, 0)});  // c50 last tick
      tbl.push_back('{1, 0, 0,  ex(3, 0, 0, 0, 1, 0)});  // c51 DONE
      tbl.push_back('{1, 1, 0,  ex(0, 0, 0, 0, 0, 0)});  // c52 IDLE, DONE ignores start/abort
      tbl.push_back('{1, 0, 0,  ex(1, 2, 0, 0, 0, 0)});  // back-to-back PRE
      tbl.push_back('{0, 0, 8,  ex(1, 2, 1, 0, 0, 0)});  // first tick 10 after start
      tbl.push_back('{0, 0, 9,  ex(1, 1, 1, 0, 0, 0)});  // second PRE tick
      tbl.push_back('{0, 1, 0,  ex(0, 0, 0, 0, 0, 1)});  // abort beats tick
      tbl.push_back('{0, 0, 0,  ex(0, 0, 0, 0, 0, 0)});
      tbl.push_back('{1, 1, 0,  ex(0, 0, 0, 0, 0, 0)});  // start+abort in IDLE
      tbl.push_back('{1, 0, 0,  ex(1, 2, 0, 0, 0, 0)});
      tbl.push_back('{0, 0, 28, ex(2, 3, 1, 0, 0, 0)});  // e=30 MEAS tick
      tbl.push_back('{0, 1, 0,  ex(0, 0, 0, 0, 0, 1)});  // abort in MEAS
      tbl.push_back('{0, 0, 3,  ex(0, 0, 0, 0, 0, 0)});  // no strobes after abort

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].st, tbl[i].ab);
         repeat (tbl[i].hold) step(1'b0, 1'b0);
         check($sformatf("tbl%0d", i), dut_v, tbl[i].exp);
      end

      // Asynchronous reset in the middle of MEAS
      step(1'b1, 1'b0);
      repeat (24) step(1'b0, 1'b0);
      check("pre_rst_meas", dut_v, ex(2, 3, 0, 0, 0, 0));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", dut_v, 11'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("rst_idle", dut_v, 11'd0);
      step(1'b1, 1'b0);
      repeat (DONE_E - 1) step(1'b0, 1'b0);
      check("rst_fullrun", dut_v, ex(3, 0, 0, 0, 1, 0));
      step(1'b0, 1'b0);

      // Randomized starts/aborts against the timeline model
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 15) == 0, $urandom_range(0, 70) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
